id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage of the LoongArch32 5-stage pipeline, directly downstream of the fetch stage.
- Latches {inst, pc} from fetch and decodes the supported subset.
- Reads the register file (internal sub-module) and resolves branches, sending a redirect back to fetch.
- Detects RAW hazards against EX/MEM, stalls as needed, and issues a decoded operation bundle to EX.

Parameters:
- RESET_PC_UNUSED, 32'h0, reset value of the latched ds_pc (not architecturally visible).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_allowin  in  1  EX can accept this cycle
- ds_allowin  out  1  ID can accept this cycle
- fs_to_ds_valid  in  1  fetch bundle valid
- fs_to_ds_bus  in  64  {inst[31:0], pc[31:0]}
- ds_to_es_valid  out  1  issue valid
- ds_to_es_bus  out  150  {alu_op[11:0], src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0]}
- br_bus  out  33  {br_taken, br_target[31:0]}
- ws_to_rf_bus  in  38  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- es_fwd_bus  in  39  {es_is_load, es_valid_we, es_dest[4:0], es_result[31:0]}
- ms_fwd_bus  in  39  {ms_is_load, ms_valid_we, ms_dest[4:0], ms_result[31:0]}

Behaviour:
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_valid loads fs_to_ds_valid when ds_allowin.
  - The bus is latched when fs_to_ds_valid && ds_allowin.
  - ds_to_es_valid = ds_valid && ds_ready_go.
- Reset values: ds_valid=0, ds_inst=0, ds_pc=0, so ds_to_es_valid=0, br_bus=0, ds_allowin=1.
- Supported instructions:
  - add.w, sub.w, slt, sltu, and, or, nor, xor
  - slli.w, srli.w, srai.w, addi.w, lu12i.w
  - ld.w, st.w
  - jirl, b, bl, beq, bne
  - Any other encoding decodes as a NOP: gr_we=0, mem_we=0, no branch. It still flows through.
- Immediates:
  - si12 sign-extended (addi, ld, st).
  - ui5 zero-extended (shifts).
  - si20<<12 (lu12i).
  - offs16<<2 sign-extended (beq, bne, jirl).
  - offs26<<2 sign-extended (b, bl).
- Register read:
  - rj read on port 1.
  - Port 2 reads rd for beq, bne, st.w; otherwise it reads rk.
  - r0 always reads 0.
- Destination:
  - bl writes r1.
  - jirl/bl write pc+4: src1_is_pc=1, imm=4.
  - st, beq, bne, b have gr_we=0.
  - dest forced to 0 when gr_we=0.
- Branch resolution:
  - br_taken = ds_valid && ds_ready_go && (beq&&rj==rkd || bne&&rj!=rkd || b || bl || jirl).
  - br_target = rj+offs16 for jirl; pc+offs for the others.
  - Purely combinational from latched state and forwarded values.
  - Held while EX stalls; the repeated redirect is idempotent.
- Hazards:
  - A source matches when it is nonzero, it is actually used by the instruction, and it equals the dest of a stage with valid_we=1.
  - Without the bypass feature: ds_ready_go=0 on any es/ms match.
- WB:
  - The regfile bypasses write data to reads of the same nonzero address in the same cycle, so WB never causes a stall.
  - The write happens at posedge when rf_we is set.
- Reset mid-operation: ds_valid clears on the next edge, and any pending branch/stall is dropped.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - Source values are forwarded with priority es > ms > regfile.
  - Stall only when the matching es stage has es_is_load=1 (load-use).
  - ms loads are forwarded, because ms_result carries the load data.
- Undefined:
  - Stall on any es/ms match.
  - *_result fields are ignored.

Decomposition:
- Shared head file (mycpu_head.v) holds the bus widths:
  - FS_TO_DS_BUS_WD=64
  - DS_TO_ES_BUS_WD=150
  - BR_BUS_WD=33
  - WS_TO_RF_BUS_WD=38
  - FWD_BUS_WD=39
  - The alu_op one-hot bit indices (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
- One sub-module: regfile. 32x32, 2 async read ports, 1 sync write port, r0 hardwired to 0, write-first read bypass.

Test Plan:
- After reset, fs bundle {addi.w r1,r0,5 = 0x02801401, pc=0x1c000000} -> next cycle ds_to_es_valid=1, alu_op=add, imm=5, dest=1, gr_we=1, br_bus=0.
- beq r1,r2 with ws writing r1=r2=7 earlier, pc=0x1c000010, offs16=4 -> br_taken=1, br_target=0x1c000020 while ds_valid. The next bundle is not latched because fs_to_ds_valid is low.
- add.w r3,r1,r2 with es_fwd_bus {0,1,1,0x11}, feature off -> ds_ready_go=0 and ds_allowin=0 until es dest clears. Feature on -> issues immediately with rj_value=0x11.
- Feature on, es_fwd_bus {1,1,2,x} and ID needs r2 -> one-cycle stall. Then ms_fwd_bus {1,1,2,0xdead} -> rkd_value=0xdead.
- Unknown encoding 0xffffffff -> issued with gr_we=0, mem_we=0, br_taken=0. Register r0 as the source of a hazard match is never stalled.
- es_allowin held 0 for 3 cycles with a valid instruction held -> ds_to_es_bus stable and ds_allowin=0. Assert reset mid-stall -> ds_to_es_valid=0 the next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared widths, alu_op bit indices, bus structs and opcodes for the
// LoongArch32 decode stage (id_stage) and its register file.
package id_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int DS_TO_ES_BUS_WD = 150;
  localparam int BR_BUS_WD       = 33;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int FWD_BUS_WD      = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        is_load;
    logic        valid_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ws_rf_t;

  // inst[31:15]
  localparam logic [16:0] OP_ADD_W  = 17'h00020;
  localparam logic [16:0] OP_SUB_W  = 17'h00022;
  localparam logic [16:0] OP_SLT    = 17'h00024;
  localparam logic [16:0] OP_SLTU   = 17'h00025;
  localparam logic [16:0] OP_NOR    = 17'h00028;
  localparam logic [16:0] OP_AND    = 17'h00029;
  localparam logic [16:0] OP_OR     = 17'h0002a;
  localparam logic [16:0] OP_XOR    = 17'h0002b;
  localparam logic [16:0] OP_SLLI_W = 17'h00081;
  localparam logic [16:0] OP_SRLI_W = 17'h00089;
  localparam logic [16:0] OP_SRAI_W = 17'h00091;
  // inst[31:22]
  localparam logic [9:0]  OP_ADDI_W = 10'h00a;
  localparam logic [9:0]  OP_LD_W   = 10'h0a2;
  localparam logic [9:0]  OP_ST_W   = 10'h0a6;
  // inst[31:25]
  localparam logic [6:0]  OP_LU12I  = 7'h0a;
  // inst[31:26]
  localparam logic [5:0]  OP_JIRL   = 6'h13;
  localparam logic [5:0]  OP_B      = 6'h14;
  localparam logic [5:0]  OP_BL     = 6'h15;
  localparam logic [5:0]  OP_BEQ    = 6'h16;
  localparam logic [5:0]  OP_BNE    = 6'h17;

  function automatic logic [31:0] sx_offs16(input logic [15:0] o);
    return {{14{o[15]}}, o, 2'b00};
  endfunction

  function automatic logic [31:0] sx_offs26(input logic [25:0] o);
    return {{4{o[25]}}, o, 2'b00};
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// r0 reads 0, same-cycle write data bypassed to matching reads.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf_q [32];

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = rf_q[raddr1_i];
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (we_i && waddr_i == raddr1_i) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = rf_q[raddr2_i];
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (we_i && waddr_i == raddr2_i) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// LoongArch32 decode stage: latch, decode, regfile read, branch resolve,
// RAW stall. Define ID_BYPASS_EN for es>ms>rf forwarding (load-use stall).
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC_UNUSED = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus
);

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_inst_q, ds_inst_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic        ds_ready_go;

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_inst_d  = ds_inst_q;
    ds_pc_d    = ds_pc_q;
    if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
    end
    if (fs_to_ds_valid && ds_allowin) begin
      {ds_inst_d, ds_pc_d} = fs_to_ds_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= '0;
      ds_pc_q    <= RESET_PC_UNUSED;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q  <= ds_inst_d;
      ds_pc_q    <= ds_pc_d;
    end
  end

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;

  logic [4:0]  rd, rj, rk;
  logic [11:0] i12;
  logic [15:0] i16;
  logic [19:0] i20;
  logic [25:0] i26;

  assign rd  = ds_inst_q[4:0];
  assign rj  = ds_inst_q[9:5];
  assign rk  = ds_inst_q[14:10];
  assign i12 = ds_inst_q[21:10];
  assign i16 = ds_inst_q[25:10];
  assign i20 = ds_inst_q[24:5];
  assign i26 = {ds_inst_q[9:0], ds_inst_q[25:10]};

  logic op_add, op_sub, op_slt, op_sltu;
  logic op_and, op_or, op_nor, op_xor;
  logic op_slli, op_srli, op_srai;
  logic op_addi, op_lu12i, op_ld, op_st;
  logic op_jirl, op_b, op_bl, op_beq, op_bne;

  assign op_add   = ds_inst_q[31:15] == OP_ADD_W;
  assign op_sub   = ds_inst_q[31:15] == OP_SUB_W;
  assign op_slt   = ds_inst_q[31:15] == OP_SLT;
  assign op_sltu  = ds_inst_q[31:15] == OP_SLTU;
  assign op_and   = ds_inst_q[31:15] == OP_AND;
  assign op_or    = ds_inst_q[31:15] == OP_OR;
  assign op_nor   = ds_inst_q[31:15] == OP_NOR;
  assign op_xor   = ds_inst_q[31:15] == OP_XOR;
  assign op_slli  = ds_inst_q[31:15] == OP_SLLI_W;
  assign op_srli  = ds_inst_q[31:15] == OP_SRLI_W;
  assign op_srai  = ds_inst_q[31:15] == OP_SRAI_W;
  assign op_addi  = ds_inst_q[31:22] == OP_ADDI_W;
  assign op_ld    = ds_inst_q[31:22] == OP_LD_W;
  assign op_st    = ds_inst_q[31:22] == OP_ST_W;
  assign op_lu12i = ds_inst_q[31:25] == OP_LU12I;
  assign op_jirl  = ds_inst_q[31:26] == OP_JIRL;
  assign op_b     = ds_inst_q[31:26] == OP_B;
  assign op_bl    = ds_inst_q[31:26] == OP_BL;
  assign op_beq   = ds_inst_q[31:26] == OP_BEQ;
  assign op_bne   = ds_inst_q[31:26] == OP_BNE;

  logic is_rrr, is_shift, is_link, src2_is_rd;
  logic rj_used, r2_used;

  assign is_rrr   = op_add | op_sub | op_slt | op_sltu |
                    op_and | op_or | op_nor | op_xor;
  assign is_shift = op_slli | op_srli | op_srai;
  assign is_link  = op_jirl | op_bl;
  assign src2_is_rd = op_beq | op_bne | op_st;
  assign rj_used  = is_rrr | is_shift | op_addi | op_ld |
                    op_st | op_jirl | op_beq | op_bne;
  assign r2_used  = is_rrr | src2_is_rd;

  ds_to_es_t ds;
  logic [4:0] raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  ws_rf_t ws;
  fwd_t   es, ms;

  assign ws     = ws_to_rf_bus;
  assign es     = es_fwd_bus;
  assign ms     = ms_fwd_bus;
  assign raddr2 = src2_is_rd ? rd : rk;

  id_stage_regfile u_rf (
    .clk_i    (clk),
    .raddr1_i (rj),
    .rdata1_o (rf_rdata1),
    .raddr2_i (raddr2),
    .rdata2_o (rf_rdata2),
    .we_i     (ws.we),
    .waddr_i  (ws.waddr),
    .wdata_i  (ws.wdata)
  );

  logic es_hit_j, es_hit_k, ms_hit_j, ms_hit_k;

  assign es_hit_j = rj_used && rj != 5'd0 &&
                    es.valid_we && es.dest == rj;
  assign es_hit_k = r2_used && raddr2 != 5'd0 &&
                    es.valid_we && es.dest == raddr2;
  assign ms_hit_j = rj_used && rj != 5'd0 &&
                    ms.valid_we && ms.dest == rj;
  assign ms_hit_k = r2_used && raddr2 != 5'd0 &&
                    ms.valid_we && ms.dest == raddr2;

  logic [31:0] rj_value, rkd_value;

`ifdef ID_BYPASS_EN
  always_comb begin
    rj_value = rf_rdata1;
    if (es_hit_j) begin
      rj_value = es.result;
    end else if (ms_hit_j) begin
      rj_value = ms.result;
    end
  end

  always_comb begin
    rkd_value = rf_rdata2;
    if (es_hit_k) begin
      rkd_value = es.result;
    end else if (ms_hit_k) begin
      rkd_value = ms.result;
    end
  end

  // ms_result already holds load data, so only an es load must wait
  assign ds_ready_go = !(es.is_load && (es_hit_j || es_hit_k));

  logic unused_fwd;
  assign unused_fwd = ms.is_load;
`else
  assign rj_value    = rf_rdata1;
  assign rkd_value   = rf_rdata2;
  assign ds_ready_go = !(es_hit_j || es_hit_k ||
                         ms_hit_j || ms_hit_k);

  logic unused_fwd;
  assign unused_fwd = ^{es.is_load, es.result,
                        ms.is_load, ms.result};
`endif

  always_comb begin
    ds = '0;
    ds.alu_op[ALU_ADD]  = op_add | op_addi | op_ld | op_st | is_link;
    ds.alu_op[ALU_SUB]  = op_sub;
    ds.alu_op[ALU_SLT]  = op_slt;
    ds.alu_op[ALU_SLTU] = op_sltu;
    ds.alu_op[ALU_AND]  = op_and;
    ds.alu_op[ALU_NOR]  = op_nor;
    ds.alu_op[ALU_OR]   = op_or;
    ds.alu_op[ALU_XOR]  = op_xor;
    ds.alu_op[ALU_SLL]  = op_slli;
    ds.alu_op[ALU_SRL]  = op_srli;
    ds.alu_op[ALU_SRA]  = op_srai;
    ds.alu_op[ALU_LUI]  = op_lu12i;
    ds.src1_is_pc   = is_link;
    ds.src2_is_imm  = is_shift | op_addi | op_lu12i |
                      op_ld | op_st | is_link;
    ds.res_from_mem = op_ld;
    ds.gr_we        = is_rrr | is_shift | op_addi |
                      op_lu12i | op_ld | is_link;
    ds.mem_we       = op_st;
    if (ds.gr_we) begin
      ds.dest = op_bl ? 5'd1 : rd;
    end
    unique case (1'b1)
      is_shift: ds.imm = {27'd0, rk};
      op_addi, op_ld, op_st:
        ds.imm = {{20{i12[11]}}, i12};
      op_lu12i: ds.imm = {i20, 12'd0};
      is_link: ds.imm = 32'd4;
      default: ds.imm = '0;
    endcase
    ds.rj_value  = rj_value;
    ds.rkd_value = rkd_value;
    ds.pc        = ds_pc_q;
  end

  assign ds_to_es_bus = ds;

  logic        br_cond, br_taken;
  logic [31:0] br_offs, br_target;

  assign br_cond  = (op_beq && rj_value == rkd_value) ||
                    (op_bne && rj_value != rkd_value) ||
                    op_b || op_bl || op_jirl;
  assign br_taken = ds_valid_q && ds_ready_go && br_cond;
  assign br_offs  = (op_b || op_bl) ? sx_offs26(i26)
                                    : sx_offs16(i16);
  assign br_target = op_jirl ? rj_value + br_offs
                             : ds_pc_q + br_offs;
  assign br_bus   = {br_taken, br_taken ? br_target : 32'h0};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: handshake, decode, branches, hazards,
// forwarding (when ID_BYPASS_EN is defined), EX backpressure and reset.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic [32:0]  br_bus;
  logic [37:0]  ws_to_rf_bus;
  logic [38:0]  es_fwd_bus;
  logic [38:0]  ms_fwd_bus;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .br_bus         (br_bus),
    .ws_to_rf_bus   (ws_to_rf_bus),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus)
  );

  wire [11:0] o_alu    = ds_to_es_bus[149:138];
  wire        o_s1pc   = ds_to_es_bus[137];
  wire        o_s2imm  = ds_to_es_bus[136];
  wire        o_gr_we  = ds_to_es_bus[134];
  wire        o_mem_we = ds_to_es_bus[133];
  wire [4:0]  o_dest   = ds_to_es_bus[132:128];
  wire [31:0] o_imm    = ds_to_es_bus[127:96];
  wire [31:0] o_rj     = ds_to_es_bus[95:64];
  wire [31:0] o_rkd    = ds_to_es_bus[63:32];
  wire [31:0] o_pc     = ds_to_es_bus[31:0];

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst,
                      input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {inst, pc};
    tick();
    fs_to_ds_valid = 1'b0;
  endtask

  logic [149:0] exp_bus;

  initial begin
    reset          = 1'b1;
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    ws_to_rf_bus   = '0;
    es_fwd_bus     = '0;
    ms_fwd_bus     = '0;
    tick();
    tick();
    chk("rst_valid", ds_to_es_valid, 0);
    chk("rst_br", br_bus, 0);
    chk("rst_allowin", ds_allowin, 1);
    reset = 1'b0;

    // addi.w r1,r0,5
    send(32'h02801401, 32'h1c000000);
    chk("addi_valid", ds_to_es_valid, 1);
    chk("addi_alu", o_alu, 12'h001);
    chk("addi_imm", o_imm, 5);
    chk("addi_dest", o_dest, 1);
    chk("addi_gr_we", o_gr_we, 1);
    chk("addi_s2imm", o_s2imm, 1);
    chk("addi_pc", o_pc, 32'h1c000000);
    chk("addi_br", br_bus, 0);

    ws_to_rf_bus = {1'b1, 5'd1, 32'd7};
    tick();
    ws_to_rf_bus = {1'b1, 5'd2, 32'd7};
    tick();
    ws_to_rf_bus = {1'b1, 5'd5, 32'h55};
    tick();
    ws_to_rf_bus = '0;
    chk("idle_valid", ds_to_es_valid, 0);

    // add.w r4,r6,r1 : r6 written in the same cycle it is read
    send(32'h001004c4, 32'h1c000008);
    ws_to_rf_bus = {1'b1, 5'd6, 32'h66};
    #1;
    chk("wb_bypass_rj", o_rj, 32'h66);
    chk("wb_no_stall", ds_to_es_valid, 1);
    tick();
    ws_to_rf_bus = '0;

    // beq r1,r2,+16
    send(32'h58001022, 32'h1c000010);
    chk("beq_br", br_bus, 33'h1_1c000020);
    chk("beq_gr_we", o_gr_we, 0);
    chk("beq_dest", o_dest, 0);
    chk("beq_rkd", o_rkd, 7);
    tick();
    chk("beq_gone_br", br_bus, 0);
    chk("beq_gone_valid", ds_to_es_valid, 0);

    // bne r1,r5,-4
    send(32'h5ffffc25, 32'h1c000200);
    chk("bne_neg_br", br_bus, 33'h1_1c0001fc);

    // bne r1,r2 (equal values) : not taken
    send(32'h5c001022, 32'h1c000210);
    chk("bne_nt_br", br_bus, 0);
    chk("bne_nt_valid", ds_to_es_valid, 1);

    // bl +32
    send(32'h54002000, 32'h1c000100);
    chk("bl_br", br_bus, 33'h1_1c000120);
    chk("bl_dest", o_dest, 1);
    chk("bl_s1pc", o_s1pc, 1);
    chk("bl_imm", o_imm, 4);

    // jirl r0,r5,+8
    send(32'h4c0008a0, 32'h1c000120);
    chk("jirl_br", br_bus, 33'h1_0000005d);

    // st.w r2,r1,8
    send(32'h29802022, 32'h1c000130);
    chk("st_mem_we", o_mem_we, 1);
    chk("st_gr_we", o_gr_we, 0);
    chk("st_imm", o_imm, 8);
    chk("st_rkd", o_rkd, 7);

    // add.w r3,r1,r2 while EX writes r1
    es_fwd_bus = {1'b0, 1'b1, 5'd1, 32'h11};
    send(32'h00100823, 32'h1c000300);
`ifdef ID_BYPASS_EN
    chk("es_fwd_valid", ds_to_es_valid, 1);
    chk("es_fwd_rj", o_rj, 32'h11);
    es_fwd_bus = '0;
    tick();
`else
    chk("es_stall_valid", ds_to_es_valid, 0);
    chk("es_stall_allowin", ds_allowin, 0);
    tick();
    chk("es_stall2_valid", ds_to_es_valid, 0);
    chk("es_stall2_allowin", ds_allowin, 0);
    es_fwd_bus = '0;
    #1;
    chk("es_clear_valid", ds_to_es_valid, 1);
    chk("es_clear_rj", o_rj, 7);
    tick();
`endif

    // add.w r3,r1,r2 while EX loads r2
    es_fwd_bus = {1'b1, 1'b1, 5'd2, 32'hbeef};
    send(32'h00100823, 32'h1c000310);
    chk("ld_use_valid", ds_to_es_valid, 0);
    chk("ld_use_allowin", ds_allowin, 0);
    tick();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 1'b1, 5'd2, 32'hdead};
    #1;
`ifdef ID_BYPASS_EN
    chk("ms_fwd_valid", ds_to_es_valid, 1);
    chk("ms_fwd_rkd", o_rkd, 32'hdead);
`else
    chk("ms_stall_valid", ds_to_es_valid, 0);
    ms_fwd_bus = '0;
    #1;
    chk("ms_clear_valid", ds_to_es_valid, 1);
    chk("ms_clear_rkd", o_rkd, 7);
`endif
    tick();
    ms_fwd_bus = '0;

    // unknown encoding
    send(32'hffffffff, 32'h1c000400);
    chk("nop_valid", ds_to_es_valid, 1);
    chk("nop_gr_we", o_gr_we, 0);
    chk("nop_mem_we", o_mem_we, 0);
    chk("nop_br", br_bus, 0);

    // add.w r3,r0,r0 with EX writing r0
    es_fwd_bus = {1'b0, 1'b1, 5'd0, 32'h99};
    send(32'h00100003, 32'h1c000410);
    chk("r0_no_stall", ds_to_es_valid, 1);
    chk("r0_rj", o_rj, 0);
    es_fwd_bus = '0;

    // EX backpressure for 3 cycles, new bundle waiting
    send(32'h02801401, 32'h1c000040);
    es_allowin     = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {32'h00100823, 32'h1c000050};
    exp_bus = {12'h001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1,
               32'd5, 32'd0, 32'h55, 32'h1c000040};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_bus", ds_to_es_bus, exp_bus);
      chk("hold_allowin", ds_allowin, 0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", ds_to_es_valid, 0);
    chk("rst_mid_br", br_bus, 0);
    chk("rst_mid_allowin", ds_allowin, 1);
    reset          = 1'b0;
    fs_to_ds_valid = 1'b0;
    es_allowin     = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
